// File: rtl/add_arb_pkg.sv
// Shared types and defaults for the round-robin adder arbiter.
package add_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int N_REQ_DEF   = 4;
  localparam int DW_DEF      = 4;
  localparam int ADD_LAT_DEF = 1;

  // Bits needed to index n items; never less than one bit
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module add_rr_pick
  import add_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int IDW  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_idx,
  output logic             any_valid
);

  // Scan from the farthest offset down to ptr so the closest set request wins
  always_comb begin
    logic [IDW:0]   pos;
    logic [IDW-1:0] idx;
    gnt_idx   = '0;
    any_valid = 1'b0;
    pos       = '0;
    idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(N_REQ)) begin
        pos = pos - (IDW+1)'(N_REQ);
      end
      idx = pos[IDW-1:0];
      if (req_valid[idx]) begin
        gnt_idx   = idx;
        any_valid = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign gnt[gi] = any_valid && (gnt_idx == IDW'(gi));
    end
  endgenerate

endmodule

// File: rtl/add_req_arbiter.sv
// Round-robin sharing of one external registered adder between N_REQ requesters.
// One operation in flight; result returned with requester ID on a valid/ready channel.
module add_req_arbiter
  import add_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF,
  localparam int IDW    = id_width(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [DW-1:0]       add_a,
  output logic [DW-1:0]       add_b,
  input  logic [DW:0]         add_sum,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [DW:0]         rsp_sum,
  output logic                busy
);

  // Counter must hold ADD_LAT itself
  localparam int CW = id_width(ADD_LAT + 1);

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             any_valid;
  logic [DW-1:0]    sel_a;
  logic [DW-1:0]    sel_b;
  logic [IDW-1:0]   ptr_next;

  add_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req_valid(req_valid),
    .ptr      (ptr),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .any_valid(any_valid)
  );

  // Grants only exist in IDLE and never while reset is asserted
  assign req_ready = (rst_n && (state == IDLE)) ? gnt : '0;

  assign sel_a    = req_a[int'(gnt_idx)*DW +: DW];
  assign sel_b    = req_b[int'(gnt_idx)*DW +: DW];
  assign ptr_next = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Arbiter FSM with registered operand, response and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            add_a  <= sel_a;
            add_b  <= sel_b;
            rsp_id <= gnt_idx;
            cnt    <= CW'(ADD_LAT);
            ptr    <= ptr_next;
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_sum   <= add_sum;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/add_req_arbiter.md
Name: add_req_arbiter

Overview:
- Shares one registered 4-bit adder datapath (inputs a/b, 5-bit registered sum, one-cycle latency) between N_REQ requesters.
- Sits between the requester ports and the adder:
  - picks one requester round-robin;
  - drives the adder operands;
  - waits out the adder latency;
  - returns the sum tagged with the requester ID over a valid/ready response channel.
- One operation is in flight at a time.

Parameters:
N_REQ, 4, number of requesters (2..16)
DW, 4, operand width; sum width is DW+1
ADD_LAT, 1, adder latency in clock edges from operand change to registered sum (>=1)
IDW, $clog2(N_REQ), requester ID width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester grant; one-hot or zero
req_a  input  N_REQ*DW  packed operand A, requester i at [i*DW +: DW]
req_b  input  N_REQ*DW  packed operand B, same packing
add_a  output  DW  operand A to adder, registered
add_b  output  DW  operand B to adder, registered
add_sum  input  DW+1  registered sum from adder
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  IDW  requester index of the response
rsp_sum  output  DW+1  captured sum
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - state IDLE, rr pointer 0, cnt 0;
  - add_a/add_b 0, rsp_valid 0, rsp_id 0, rsp_sum 0, busy 0;
  - req_ready forced 0 while rst_n low.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready[g]=1 combinationally only for the winner g, and only when any req_valid is set.
  - Winner g is the first set req_valid scanning from ptr upward, wrapping N_REQ-1 -> 0.
  - On the edge where req_valid[g] && req_ready[g]:
    - add_a <= req_a[g], add_b <= req_b[g];
    - rsp_id <= g, cnt <= ADD_LAT;
    - ptr <= (g+1) mod N_REQ;
    - state -> WAIT.
- WAIT:
  - req_ready all 0.
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: rsp_sum <= add_sum, rsp_valid <= 1, state -> RESP.
  - Result: rsp_valid rises ADD_LAT+1 cycles after the grant edge (2 cycles at default).
- RESP:
  - rsp_valid, rsp_id and rsp_sum are held stable until rsp_ready.
  - On the rsp_valid && rsp_ready edge: rsp_valid <= 0, state -> IDLE.
  - No grant is issued in the handshake cycle; the earliest next grant is the following cycle.
- add_a/add_b hold their value from one grant until the next; they are never cleared except by reset.
- Arithmetic: the adder output is taken as-is, DW+1 bits, no truncation; max 15+15=30 at DW=4.
- Requesters must hold req_valid and operands until req_ready. A valid dropped before grant is simply not serviced; no error is raised.
- All requesters valid: grants strictly rotate; no requester waits more than N_REQ-1 other operations.
- Pointer wrap: a grant to N_REQ-1 sets ptr to 0.
- Reset mid-operation (WAIT or RESP): the in-flight operation is discarded, with no response after release; ptr returns to 0.
- rsp_ready high in advance: rsp_valid is a single-cycle pulse; throughput is one op per ADD_LAT+3 cycles.

Decomposition:
- Package add_arb_pkg holds:
  - state enum typedef (IDLE, WAIT, RESP);
  - default constants for N_REQ, DW, ADD_LAT;
  - an ID-width helper function.
- Sub-module add_rr_pick: combinational round-robin picker. Inputs req_valid and ptr; outputs gnt one-hot, gnt_idx and any_valid.
- The FSM, operand/response registers and the latency counter stay in add_req_arbiter. The adder itself stays external.

Test Plan:
- Single request: req_valid[2]=1, a=4, b=3, rsp_ready=1 -> req_ready[2] high one cycle, add_a=4/add_b=3 after the grant edge, rsp_valid 2 cycles later with rsp_id=2, rsp_sum=7, busy 1 throughout.
- All four valid continuously with distinct operands, rsp_ready=1 -> grant order 0,1,2,3,0,1, and each rsp_id/rsp_sum matches its requester.
- Maximum operands: a=15, b=15 -> rsp_sum=30 (5'b11110), no overflow.
- Backpressure: rsp_ready=0 for 5 cycles while in RESP, requesters 0 and 1 valid -> rsp_valid/id/sum stable, req_ready all 0; raise rsp_ready -> IDLE next cycle, then grant to ptr's winner.
- Reset during WAIT: drop rst_n for 1 cycle -> all outputs 0 immediately, no rsp_valid for the discarded op; after release req_valid[3] is granted and ptr becomes 0.
- ADD_LAT=3 build: single request a=9, b=6 -> rsp_valid exactly 4 cycles after the grant edge, rsp_sum=15.
